// File: rtl/shift_ctrl.sv
// Button/switch front end for the LED shift register: synchronize, debounce,
// turn presses into the one-hot command word, capture switches, make the strobe.
module shift_ctrl #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int STROBE_HZ       = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnl,
  input  logic       btnu,
  input  logic       btnr,
  input  logic       btnd,
  input  logic [7:0] sw,
  output logic [3:0] state,
  output logic [7:0] d_in,
  output logic       strobe_1hz
);

  localparam int PERIOD = CLK_HZ / STROBE_HZ;
  localparam int STB_W  = $clog2(PERIOD);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_PRE  = STB_W'(PERIOD - 2);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(PERIOD - 1);

  typedef enum logic [1:0] {
    MODE_NONE,
    MODE_LEFT,
    MODE_RIGHT
  } mode_t;

  // Button bit order matches the command word: 0=left 1=load 2=right 3=clear.
  logic [3:0]      btn_raw;
  logic [3:0]      btn_p0, btn_p1;
  logic [7:0]      sw_p0, sw_p1;
  logic [3:0]      db_p2, db_p3;
  logic [DB_W-1:0] db_cnt [4];
  logic [3:0]      press;

  mode_t           mode;
  logic            load_q, clr_q;
  logic [7:0]      d_q;

  logic [STB_W-1:0] stb_cnt;
  logic             stb_q;

  assign btn_raw = {btnd, btnr, btnu, btnl};

  // Stage p0/p1: two-flop synchronizers for buttons and switches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_p0 <= '0;
      btn_p1 <= '0;
      sw_p0  <= '0;
      sw_p1  <= '0;
    end else begin
      btn_p0 <= btn_raw;
      btn_p1 <= btn_p0;
      sw_p0  <= sw;
      sw_p1  <= sw_p0;
    end
  end

  // Stage p2: per-button debounce; level flips after DEBOUNCE_CYCLES stable mismatches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      db_p2 <= '0;
      db_p3 <= '0;
    end else begin
      db_p3 <= db_p2;
      for (int i = 0; i < 4; i++) begin
        if (btn_p1[i] == db_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_p2[i]  <= ~db_p2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign press = db_p2 & ~db_p3;

  // Stage p3: command register; clear beats left/right, simultaneous left+right holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode   <= MODE_NONE;
      load_q <= 1'b0;
      clr_q  <= 1'b0;
      d_q    <= '0;
    end else begin
      load_q <= press[1];
      clr_q  <= press[3];
      if (press[1]) d_q <= sw_p1;
      if (press[3])                   mode <= MODE_NONE;
      else if (press[0] && !press[2]) mode <= MODE_LEFT;
      else if (press[2] && !press[0]) mode <= MODE_RIGHT;
    end
  end

  assign state = {clr_q, (mode == MODE_RIGHT), load_q, (mode == MODE_LEFT)};
  assign d_in  = d_q;

  // Free-running strobe; the pulse is registered one count early so it lines up with the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_cnt <= '0;
      stb_q   <= 1'b0;
    end else begin
      stb_cnt <= (stb_cnt == STB_LAST) ? '0 : stb_cnt + STB_W'(1);
      stb_q   <= (stb_cnt == STB_PRE);
    end
  end

  assign strobe_1hz = stb_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl with CLK_HZ=20, STROBE_HZ=1, DEBOUNCE_CYCLES=4.
module tb_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btnl, btnu, btnr, btnd;
  logic [7:0] sw;
  logic [3:0] state;
  logic [7:0] d_in;
  logic       strobe_1hz;

  int n_cmp = 0;
  int n_err = 0;

  shift_ctrl #(
    .CLK_HZ         (20),
    .STROBE_HZ      (1),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btnl      (btnl),
    .btnu      (btnu),
    .btnr      (btnr),
    .btnd      (btnd),
    .sw        (sw),
    .state     (state),
    .d_in      (d_in),
    .strobe_1hz(strobe_1hz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Advance one clock and park on the falling edge, where inputs change and outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold current buttons for n cycles, expecting `pre` before cycle k, `at` at cycle k, `post` after.
  task automatic expect_seq(input string tag, input int n, input int k,
                            input logic [3:0] pre, input logic [3:0] at, input logic [3:0] post);
    for (int i = 1; i <= n; i++) begin
      step();
      check(tag, 8'(state), 8'((i < k) ? pre : (i == k) ? at : post));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btnl = 1'b0; btnu = 1'b0; btnr = 1'b0; btnd = 1'b0;
    sw = 8'h00;
    repeat (3) @(negedge clk);

    // 1. Reset values, then strobe at cycles 19, 39, 59.
    check("rst_state", 8'(state), 8'h00);
    check("rst_d_in", d_in, 8'h00);
    check("rst_strobe", 8'(strobe_1hz), 8'h00);
    rst_n = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step();
      check("strobe", 8'(strobe_1hz), 8'((i % 20) == 19));
      check("idle_state", 8'(state), 8'h00);
    end

    // 2. Load A5: one pulse at rise+7, d_in holds after release and switch change.
    sw = 8'hA5;
    step();
    btnu = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      check("load_state", 8'(state), (i == 7) ? 8'h02 : 8'h00);
      if (i == 7) check("load_d_in", d_in, 8'hA5);
    end
    btnu = 1'b0;
    sw = 8'h5A;
    expect_seq("load_release", 10, 0, 4'b0000, 4'b0000, 4'b0000);
    check("load_hold_d_in", d_in, 8'hA5);

    // 3. Bounce on left: glitches rejected, mode set at stable-hold+7.
    for (int g = 0; g < 4; g++) begin
      btnl = ~g[0];
      step();
      check("bounce_glitch", 8'(state), 8'h00);
      step();
      check("bounce_glitch", 8'(state), 8'h00);
    end
    btnl = 1'b1;
    expect_seq("bounce_hold", 12, 7, 4'b0000, 4'b0001, 4'b0001);
    btnl = 1'b0;
    expect_seq("left_release", 8, 0, 4'b0001, 4'b0001, 4'b0001);

    // 4. Right press moves left -> right in one cycle, never both.
    btnr = 1'b1;
    expect_seq("mode_right", 12, 7, 4'b0001, 4'b0100, 4'b0100);
    btnr = 1'b0;
    expect_seq("right_release", 8, 0, 4'b0100, 4'b0100, 4'b0100);

    // 5a. Left+right together leave mode right untouched.
    btnl = 1'b1;
    btnr = 1'b1;
    expect_seq("lr_same", 12, 0, 4'b0100, 4'b0100, 4'b0100);
    btnl = 1'b0;
    btnr = 1'b0;
    expect_seq("lr_release", 8, 0, 4'b0100, 4'b0100, 4'b0100);

    // 5b. Clear+right together: clear wins, one-cycle 1000 then 0000.
    btnd = 1'b1;
    btnr = 1'b1;
    expect_seq("clr_right", 12, 7, 4'b0100, 4'b1000, 4'b0000);
    btnd = 1'b0;
    btnr = 1'b0;
    expect_seq("clr_release", 8, 0, 4'b0000, 4'b0000, 4'b0000);

    // 6. Mode left, then reset mid-debounce of a held load button.
    btnl = 1'b1;
    expect_seq("pre_rst_left", 8, 7, 4'b0000, 4'b0001, 4'b0001);
    btnl = 1'b0;
    sw = 8'h3C;
    expect_seq("pre_rst_rel", 8, 0, 4'b0001, 4'b0001, 4'b0001);
    btnu = 1'b1;
    repeat (5) step();
    check("pre_rst_state", 8'(state), 8'h01);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_state", 8'(state), 8'h00);
    check("async_rst_d_in", d_in, 8'h00);
    check("async_rst_strobe", 8'(strobe_1hz), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("post_rst_load", 8'(state), (i == 7) ? 8'h02 : 8'h00);
      if (i == 7) check("post_rst_d_in", d_in, 8'h3C);
    end
    btnu = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_ctrl.md
# shift_ctrl

Command generator driving the LED shift register: synchronizes and debounces the four board buttons, converts presses into the one-hot `state` command word, captures the switch bank as the load value, and generates the 1 Hz shift strobe. Sits between the board I/O (btnl/btnu/btnr/btnd, sw) and the shift register's `state`, `d_in`, and `strobe_1hz` inputs.

## Interface
- `CLK_HZ`, 100_000_000: input clock frequency.
- `STROBE_HZ`, 1: strobe rate. Strobe period is `CLK_HZ/STROBE_HZ` cycles, which must be ≥ 2.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles needed to accept a button level change. Must be ≥ 1.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `btnl` in 1: raw button, select left-shift mode.
- `btnu` in 1: raw button, load switches.
- `btnr` in 1: raw button, select right-shift mode.
- `btnd` in 1: raw button, clear.
- `sw` in 8: raw switch bank.
- `state` out 4: command word.
  - bit0 = left-shift mode (level)
  - bit1 = load (1-cycle pulse)
  - bit2 = right-shift mode (level)
  - bit3 = clear (1-cycle pulse)
- `d_in` out 8: captured switch value, valid whenever `state[1]` is high.
- `strobe_1hz` out 1: 1-cycle pulse every strobe period.

## Operation
- **Synchronization:** each button and each switch bit passes through a 2-flop synchronizer.
- **Debounce (per button):**
  - The debounced level is 0 at reset.
  - A counter increments while the synced level differs from the debounced level and resets to 0 whenever they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
- **Press detection:** a debounced 0→1 transition yields a registered 1-cycle press pulse. Releases generate nothing.
- **Mode register** (none / left / right), reset to none:
  - left press only → left.
  - right press only → right.
  - left and right pressed in the same cycle → mode unchanged.
  - clear press → none, overriding any same-cycle left/right press.
  - `state[0]` = (mode == left), `state[2]` = (mode == right). The two bits are never both high.
- **Load:**
  - On a load press, the synced `sw` is captured into the `d_in` register.
  - `state[1]` pulses high for exactly one cycle, coincident with the new `d_in`.
  - `d_in` holds its value until the next load.
- **Clear:** on a clear press, `state[3]` pulses high for one cycle.
- **Simultaneous load and clear:** both pulses are emitted. The receiver gives clear priority. `d_in` still updates.
- **Mode during load/clear:** the mode register is unchanged by load. It is only changed by clear as described above.
- **Strobe:**
  - Free-running counter from 0 to `CLK_HZ/STROBE_HZ - 1`.
  - `strobe_1hz` is high in the cycle the counter is at its terminal value, then the counter wraps to 0.
  - The counter is not affected by mode changes or button activity.

## Timing
- **Reset values:** `state` = 4'b0000, `d_in` = 8'h00, `strobe_1hz` = 0. All counters are 0, debounced levels are 0, mode is none.
- **Press latency:** a raw button rising at cycle 0 and held produces its effect on the outputs at cycle `DEBOUNCE_CYCLES + 3`:
  - 2 cycles synchronizer
  - `DEBOUNCE_CYCLES` cycles stable count
  - 1 cycle edge register
  - The mode bit change and the load/clear pulse occur in that same cycle.
- **Captured switch value:** `d_in` takes the `sw` value that was present 2 cycles before the load pulse.
- **Bounce:** a raw glitch shorter than `DEBOUNCE_CYCLES` cycles produces no output change. A press held arbitrarily long yields exactly one pulse or mode change.
- **First strobe:** the first strobe after reset release occurs at cycle `CLK_HZ/STROBE_HZ - 1`. Later strobes follow every `CLK_HZ/STROBE_HZ` cycles.
- **Reset mid-operation:** asynchronous assertion forces all outputs to their reset values immediately. A button held through reset release produces a press pulse `DEBOUNCE_CYCLES + 3` cycles after release.

## Test plan
Bench parameters for all scenarios: `CLK_HZ`=20, `STROBE_HZ`=1, `DEBOUNCE_CYCLES`=4.
1. **Reset and strobe:** release `rst_n`, no buttons → outputs 0; `strobe_1hz` high at cycles 19, 39, 59, each exactly 1 cycle wide.
2. **Load:** `sw`=8'hA5, hold `btnu` 20 cycles → `state`=4'b0010 for exactly 1 cycle at rise+7 with `d_in`=8'hA5; `d_in` holds A5 after release; no second pulse.
3. **Bounce rejection:** toggle `btnl` 1,0,1,0 at 2-cycle intervals, then hold high → `state[0]` rises only at (start of stable hold)+7; no earlier change.
4. **Mode switch:** press `btnl` then `btnr` → `state` goes 0001, then 0100; never 0101.
5. **Simultaneous presses:**
   - `btnl`+`btnr` same cycle from mode right → stays 0100.
   - `btnd`+`btnr` same cycle → 4'b1000 pulse, then 0000.
6. **Reset mid-debounce:** assert `rst_n`=0 while `btnu` is held at rise+5 → immediate all-zero; release with `btnu` still held → load pulse at release+7.
